// File: rtl/aes256_pkg.sv
// aes256_pkg: shared AES-256 constants and the round controller state type.
package aes256_pkg;
   localparam int AES_NR  = 14;
   localparam int ROUND_W = 4;
   typedef enum logic [2:0] {
      IDLE,
      KEY_WAIT,
      WRITE,
      WAIT_FULL,
      WAIT_EMPTY,
      DONE
   } round_ctrl_state_t;
endpackage

// File: rtl/aes256_round_ctrl.sv
// aes256_round_ctrl: sequences rounds 0..NR through key fetch, state register write and register handshake.
module aes256_round_ctrl
   import aes256_pkg::*;
#(
   parameter int NR      = AES_NR,
   parameter int TIMEOUT = 15
) (
   input  logic               clk,
   input  logic               resetn,
   input  logic               start,
   input  logic               abort,
   input  logic               key_vld,
   input  logic               reg_full,
   output logic               busy,
   output logic               done,
   output logic               err,
   output logic [ROUND_W-1:0] round,
   output logic               key_req,
   output logic               sel_in,
   output logic               skip_mix,
   output logic               reg_wr_en
);
   localparam int CW = $clog2(TIMEOUT + 1);
   localparam logic [ROUND_W-1:0] LAST = ROUND_W'(NR);
   round_ctrl_state_t state, state_nxt;
   logic [CW-1:0] cnt;
   logic waiting, tmo, timed_out, accept, advance;
   always_comb begin
      state_nxt = state;
      waiting   = (state == WAIT_FULL) || (state == WAIT_EMPTY);
      tmo       = waiting && (cnt == CW'(TIMEOUT - 1));
      unique case (state)
         IDLE:       state_nxt = (start && !abort) ? KEY_WAIT : IDLE;
         KEY_WAIT:   state_nxt = key_vld ? WRITE : KEY_WAIT;
         WRITE:      state_nxt = WAIT_FULL;
         WAIT_FULL:  state_nxt = tmo ? IDLE : reg_full ? WAIT_EMPTY : WAIT_FULL;
         WAIT_EMPTY: state_nxt = tmo ? IDLE : reg_full ? WAIT_EMPTY : (round == LAST) ? DONE : KEY_WAIT;
         DONE:       state_nxt = IDLE;
         default:    state_nxt = IDLE;
      endcase
      if (abort && state != IDLE) state_nxt = IDLE;
      timed_out = tmo && !abort;
      accept    = (state == IDLE) && (state_nxt == KEY_WAIT);
      advance   = (state == WAIT_EMPTY) && (state_nxt == KEY_WAIT);
   end
   // the handshake counter restarts on every state change, so each wait phase is timed from its entry
   always_ff @(posedge clk) begin
      if (resetn) begin
         state <= IDLE;
         cnt   <= '0;
         round <= '0;
         err   <= 1'b0;
      end else begin
         state <= state_nxt;
         cnt   <= (state_nxt != state || !waiting) ? '0 : cnt + 1'b1;
         if (accept) round <= '0;
         else if (advance && round != LAST) round <= round + 1'b1;
         if (accept) err <= 1'b0;
         else if (timed_out) err <= 1'b1;
      end
   end
   assign busy      = (state != IDLE);
   assign done      = (state == DONE);
   assign key_req   = (state == KEY_WAIT);
   assign reg_wr_en = (state == WRITE);
   assign sel_in    = busy && (round == '0);
   assign skip_mix  = busy && (round == LAST);
endmodule

// File: tb/tb_aes256_round_ctrl.sv
// tb_aes256_round_ctrl: directed table and sequence checks of the AES-256 round controller.
module tb_aes256_round_ctrl;
   logic clk = 1'b0, resetn = 1'b1, start = 1'b0, abort = 1'b0, key_vld = 1'b1, reg_full;
   logic busy, done, err, key_req, sel_in, skip_mix, reg_wr_en;
   logic [3:0] round;
   logic model_en = 1'b1;
   int checks = 0, failures = 0;
   logic [9:0] s_h [0:127];
   logic       e_h [0:127];
   typedef struct {
      int         c;
      logic [9:0] exp;
   } vec_t;
   vec_t tab [12];
   aes256_round_ctrl dut (
      .clk(clk), .resetn(resetn), .start(start), .abort(abort), .key_vld(key_vld),
      .reg_full(reg_full), .busy(busy), .done(done), .err(err), .round(round),
      .key_req(key_req), .sel_in(sel_in), .skip_mix(skip_mix), .reg_wr_en(reg_wr_en)
   );
   always #5 clk = ~clk;
   // state register model: full the cycle after a write, empty again one cycle later
   always @(posedge clk) reg_full <= resetn ? 1'b0 : (model_en && reg_wr_en);
   task automatic step();
      @(posedge clk);
      #1;
   endtask
   task automatic chk(input string name, input int c, input int got, input int exp);
      checks++;
      if (got !== exp) begin
         failures++;
         $display("FAIL %s cycle=%0d got=%0h expected=%0h", name, c, got, exp);
      end
   endtask
   task automatic run_block(input int ks_lo, input int ks_hi, input int ab_at, input int st_at,
                            input int rs_at, output int done_at, output int ndone);
      done_at = -1;
      ndone   = 0;
      key_vld = 1'b1;
      start   = 1'b1;
      step();
      start = 1'b0;
      for (int c = 1; c <= 70; c++) begin
         s_h[c] = {busy, done, key_req, reg_wr_en, sel_in, skip_mix, round};
         e_h[c] = err;
         if (done) begin
            ndone++;
            if (done_at < 0) done_at = c;
         end
         key_vld = !(c >= ks_lo && c <= ks_hi);
         abort   = (c == ab_at);
         start   = (c == st_at);
         resetn  = (c == rs_at);
         step();
      end
      abort  = 1'b0;
      start  = 1'b0;
      resetn = 1'b0;
   endtask
   initial begin
      int da, nd;
      tab[0]  = '{1,  {6'b101010, 4'd0}};
      tab[1]  = '{2,  {6'b100110, 4'd0}};
      tab[2]  = '{3,  {6'b100010, 4'd0}};
      tab[3]  = '{4,  {6'b100010, 4'd0}};
      tab[4]  = '{5,  {6'b101000, 4'd1}};
      tab[5]  = '{6,  {6'b100100, 4'd1}};
      tab[6]  = '{22, {6'b100100, 4'd5}};
      tab[7]  = '{56, {6'b100000, 4'd13}};
      tab[8]  = '{57, {6'b101001, 4'd14}};
      tab[9]  = '{58, {6'b100101, 4'd14}};
      tab[10] = '{60, {6'b100001, 4'd14}};
      tab[11] = '{62, {6'b000000, 4'd14}};
      step();
      step();
      resetn = 1'b0;
      step();
      chk("reset_outputs", 0, {busy, done, err, key_req, reg_wr_en, sel_in, skip_mix, round}, 0);
      // nominal block
      run_block(0, -1, -1, -1, -1, da, nd);
      for (int i = 0; i < 12; i++) chk("table", tab[i].c, s_h[tab[i].c], tab[i].exp);
      for (int c = 1; c <= 62; c++) begin
         chk("wr_en", c, s_h[c][6], (c % 4 == 2) && c <= 58);
         chk("done", c, s_h[c][8], c == 61);
         chk("busy", c, s_h[c][9], c <= 61);
         chk("sel_in", c, s_h[c][5], c <= 4);
         if (c <= 60) chk("skip_mix", c, s_h[c][4], c >= 57);
      end
      chk("nominal_done_count", 0, nd, 1);
      // key stall in round 5
      run_block(21, 23, -1, -1, -1, da, nd);
      chk("stall_round", 22, s_h[22][3:0], 5);
      chk("stall_key_req", 22, s_h[22][7], 1);
      chk("stall_round", 24, s_h[24][3:0], 5);
      chk("stall_key_req", 24, s_h[24][7], 1);
      chk("stall_write", 25, s_h[25][6], 1);
      chk("stall_done_at", 0, da, 64);
      chk("stall_done_count", 0, nd, 1);
      // register never fills
      model_en = 1'b0;
      run_block(0, -1, -1, -1, -1, da, nd);
      model_en = 1'b1;
      chk("tmo_busy", 17, s_h[17][9], 1);
      chk("tmo_err", 17, e_h[17], 0);
      chk("tmo_busy", 18, s_h[18][9], 0);
      chk("tmo_err", 18, e_h[18], 1);
      chk("tmo_err_sticky", 70, e_h[70], 1);
      chk("tmo_no_done", 0, nd, 0);
      run_block(0, -1, -1, -1, -1, da, nd);
      chk("err_cleared", 1, e_h[1], 0);
      chk("after_tmo_done_at", 0, da, 61);
      // abort in round 7 WAIT_EMPTY
      run_block(0, -1, 32, -1, -1, da, nd);
      chk("abort_pre_busy", 32, s_h[32][9], 1);
      chk("abort_pre_round", 32, s_h[32][3:0], 7);
      chk("abort_busy", 33, s_h[33][9], 0);
      chk("abort_round", 33, s_h[33][3:0], 7);
      chk("abort_err", 33, e_h[33], 0);
      chk("abort_no_done", 0, nd, 0);
      // start together with abort in IDLE
      start = 1'b1;
      abort = 1'b1;
      step();
      start = 1'b0;
      abort = 1'b0;
      chk("start_abort_busy", 1, busy, 0);
      step();
      chk("start_abort_key_req", 2, key_req, 0);
      // start re-pulsed mid-block
      run_block(0, -1, -1, 30, -1, da, nd);
      chk("restart_done_at", 0, da, 61);
      chk("restart_done_count", 0, nd, 1);
      chk("restart_round", 31, s_h[31][3:0], 7);
      // reset during round 10 WRITE
      run_block(0, -1, -1, -1, 42, da, nd);
      chk("rst_pre_write", 42, s_h[42], {6'b100100, 4'd10});
      chk("rst_outputs", 43, s_h[43], 0);
      chk("rst_err", 43, e_h[43], 0);
      chk("rst_no_done", 0, nd, 0);
      step();
      run_block(0, -1, -1, -1, -1, da, nd);
      chk("post_rst_done_at", 0, da, 61);
      chk("post_rst_done_count", 0, nd, 1);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
